// File: rtl/uart_rx_word_packer.sv
// uart_rx_word_packer
// Packs received UART bytes (first byte in the LSBs) into DATA_WIDTH words and
// buffers them in a FIFO_DEPTH-entry FIFO with a valid/ready output handshake.
// Optional feature macro: UART_RX_TIMEOUT_EN. When it is defined, a partial word
// is flushed zero-padded after TIMEOUT_TICKS idle baud ticks.
module uart_rx_word_packer #(
    parameter int DATA_WIDTH    = 32,
    parameter int FIFO_DEPTH    = 4,
    parameter int TIMEOUT_TICKS = 64,
    localparam int BYTES = DATA_WIDTH / 8,
    localparam int CW    = $clog2(BYTES + 1),
    localparam int FW    = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  baudTick,
    input  logic [7:0]            byteIn,
    input  logic                  byteValid,
    output logic [DATA_WIDTH-1:0] wordOut,
    output logic [CW-1:0]         wordBytes,
    output logic                  wordValid,
    input  logic                  wordReady,
    output logic [FW-1:0]         fifoCount,
    output logic                  overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] r_pack;
    logic [CW-1:0]         r_cnt;
    logic [DATA_WIDTH-1:0] r_memData  [FIFO_DEPTH];
    logic [CW-1:0]         r_memBytes [FIFO_DEPTH];
    logic [AW-1:0]         r_wrPtr;
    logic [AW-1:0]         r_rdPtr;
    logic [FW-1:0]         r_count;
    logic                  r_overflow;
    logic [DATA_WIDTH-1:0] r_wordOut;
    logic [CW-1:0]         r_wordBytes;

    logic [DATA_WIDTH-1:0] w_packNext;
    logic                  w_lastByte;
    logic                  w_expire;
    logic                  w_push;
    logic [DATA_WIDTH-1:0] w_pushData;
    logic [CW-1:0]         w_pushBytes;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_pushOk;
    logic [AW-1:0]         w_rdNext;

`ifdef UART_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);

    logic [TW-1:0] r_tmo;

    // Idle-tick counter: counts baud ticks while a partial word is held, restarts on every byte
    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_tmo <= '0;
        end else if (byteValid || w_expire || (r_cnt == '0)) begin
            r_tmo <= '0;
        end else if (baudTick) begin
            r_tmo <= r_tmo + 1'b1;
        end
    end

    // Expiry fires on the tick that would make the counter reach TIMEOUT_TICKS; a byte on that edge wins
    assign w_expire = (r_cnt != '0) && !byteValid && baudTick &&
                      (r_tmo == TW'(TIMEOUT_TICKS - 1));
`else
    logic w_unusedTick;

    // No flush path: partial words wait for the rest of their bytes
    assign w_expire     = 1'b0;
    assign w_unusedTick = baudTick & (TIMEOUT_TICKS > 0);
`endif

    // Merge the incoming byte into its lane and decide what, if anything, is pushed this edge
    always_comb begin
        w_packNext = r_pack;
        for (int i = 0; i < BYTES; i++) begin
            if (r_cnt == CW'(i)) begin
                w_packNext[i*8 +: 8] = byteIn;
            end
        end
        w_lastByte  = (r_cnt == CW'(BYTES - 1));
        w_push      = byteValid && w_lastByte;
        w_pushData  = w_packNext;
        w_pushBytes = CW'(BYTES);
        if (w_expire) begin
            w_push      = 1'b1;
            w_pushData  = r_pack;
            w_pushBytes = r_cnt;
        end
    end

    assign w_pop     = (r_count != '0) && wordReady;
    assign w_full    = (r_count == FW'(FIFO_DEPTH));
    assign w_pushOk  = w_push && (!w_full || w_pop);
    assign w_rdNext  = r_rdPtr + 1'b1;

    // Byte packer: cnt walks the lanes, and the pack register empties whenever a word leaves it
    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_pack <= '0;
            r_cnt  <= '0;
        end else if (byteValid) begin
            if (w_lastByte) begin
                r_pack <= '0;
                r_cnt  <= '0;
            end else begin
                r_pack <= w_packNext;
                r_cnt  <= r_cnt + 1'b1;
            end
        end else if (w_expire) begin
            r_pack <= '0;
            r_cnt  <= '0;
        end
    end

    // FIFO storage: an accepted push lands at the write pointer (on full+pop it reuses the popped slot)
    always_ff @(posedge clk) begin
        if (rstN && w_pushOk) begin
            r_memData[r_wrPtr]  <= w_pushData;
            r_memBytes[r_wrPtr] <= w_pushBytes;
        end
    end

    // FIFO control and registered head: output tracks the entry at the read pointer after each edge
    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_wordOut   <= '0;
            r_wordBytes <= '0;
        end else begin
            if (w_pushOk) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= w_rdNext;
            end
            if (w_pushOk && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_pushOk && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (w_push && !w_pushOk) begin
                r_overflow <= 1'b1;
            end
            if (w_pop && (r_count > FW'(1))) begin
                r_wordOut   <= r_memData[w_rdNext];
                r_wordBytes <= r_memBytes[w_rdNext];
            end else if (w_pushOk && ((r_count == '0) || (w_pop && (r_count == FW'(1))))) begin
                r_wordOut   <= w_pushData;
                r_wordBytes <= w_pushBytes;
            end
        end
    end

    assign wordOut   = r_wordOut;
    assign wordBytes = r_wordBytes;
    assign wordValid = (r_count != '0);
    assign fifoCount = r_count;
    assign overflow  = r_overflow;

endmodule
